fetch_queue_stage: RTL and testbench
====================================

# fetch_queue_stage

Parametrised instruction-fetch front end. Issues aligned line reads to instruction memory with up to MAX_OUTSTANDING reads in flight. Unpacks each returned line into INSTRS_PER_LINE 32-bit instructions, each tagged with its PC, and holds them in a QUEUE_DEPTH-entry FIFO that feeds the decode/rename path. Handles redirects by flushing the queue and discarding stale in-flight responses.

## Interface
Parameters:
- INSTRS_PER_LINE, 2: instructions per memory line; power of 2, ≥1. LINE_BYTES = 4*INSTRS_PER_LINE.
- QUEUE_DEPTH, 8: FIFO entries; power of 2, ≥ INSTRS_PER_LINE.
- MAX_OUTSTANDING, 2: maximum reads in flight, ≥1.
- RESET_PC, 64'h0: fetch PC after reset; 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_ren  out  1  read request this cycle; the memory accepts it unconditionally.
- mem_raddr  out  64  line-aligned read address; 0 when mem_ren=0.
- mem_rvalid  in  1  read data valid. Responses return in request order, ≥1 cycle after the request.
- mem_rdata  in  32*INSTRS_PER_LINE  line data; slot i is bits [32i+31:32i] at address base+4i.
- set_pc_valid  in  1  redirect strobe.
- set_pc  in  64  redirect target; 4-byte aligned.
- output_valid  out  1  queue non-empty.
- raw_instr  out  32  head instruction; 0 when empty.
- instr_pc  out  64  head PC; 0 when empty.
- stall  in  1  downstream not ready; head consumed when output_valid && !stall.

## Operation
State:
- fetch_pc: next fetch address.
- FIFO: instr and pc per entry; head/tail pointers; count 0..QUEUE_DEPTH.
- outstanding: 0..MAX_OUTSTANDING.
- drop_cnt: stale responses still to discard.
- Offset FIFO: MAX_OUTSTANDING entries holding the start slot of each request.

Issue (combinational mem_ren) when all of these hold:
- !rst and !set_pc_valid
- outstanding < MAX_OUTSTANDING
- count + (outstanding − drop_cnt)*INSTRS_PER_LINE + INSTRS_PER_LINE ≤ QUEUE_DEPTH

On issue:
- mem_raddr = fetch_pc & ~(LINE_BYTES−1).
- Push start slot (fetch_pc[log2(LINE_BYTES)-1:2]) into the offset FIFO.
- fetch_pc ← line base + LINE_BYTES.

Response (mem_rvalid):
- Pop the offset FIFO; outstanding decrements.
- If drop_cnt>0: discard the data and decrement drop_cnt.
- Otherwise enqueue slots start..INSTRS_PER_LINE−1 in ascending order, pc = base + 4*slot. The first line after a redirect is therefore partial.
- Line base for each response is carried alongside its offset entry.
- Space is guaranteed by the issue rule. Overflow is a design error; assert on it.

Dequeue: when output_valid && !stall, the head pops. stall does not block fetching.

Redirect (set_pc_valid), which has priority over everything else:
- FIFO cleared (count=0).
- fetch_pc ← set_pc.
- drop_cnt ← outstanding + (issue this cycle ? 1 : 0) − (mem_rvalid ? 1 : 0). Issue is suppressed on a redirect, so the first term is 0.
- A response arriving in the redirect cycle is discarded.
- Any dequeue or enqueue in that cycle is void.

Counters:
- outstanding += issue − mem_rvalid.
- count += enqueued − dequeued; both may happen in the same cycle.
- mem_rvalid while outstanding=0 is illegal; assert on it.

## Timing
Reset (asynchronous, immediate):
- count=0, outstanding=0, drop_cnt=0, fetch_pc=RESET_PC.
- Outputs: output_valid=0, mem_ren=0, mem_raddr=0, raw_instr=0, instr_pc=0.
- Reset mid-flight: on release, responses to pre-reset requests must not arrive; the memory is reset together with this block.

Cycle-level behaviour:
- mem_ren can assert in the first cycle after reset release.
- With a 1-cycle memory: request in cycle N, mem_rvalid in N+1, output_valid in N+2. The queue is show-ahead: entries are visible the cycle after they are written.
- Redirect sampled at edge E: the first request is in cycle E+1, and output_valid remains 0 through at least E+2.
- Steady state with MAX_OUTSTANDING=2 and a 1-cycle memory: one line per cycle, bounded by the issue rule.
- Full queue with stall held: mem_ren stays 0 and output holds the head stable.

## Test plan
- **Reset/stream:** RESET_PC=0, 1-cycle memory returning word = address, stall=0. Required: mem_raddr 0x0,0x8,0x10…; outputs pc 0,4,8,… with raw_instr = pc in order, no gaps.
- **Partial line:** set_pc=0x14, INSTRS_PER_LINE=4. Required: first request 0x10; outputs pc 0x14,0x18,0x1C, then 0x20.
- **Stale drop:** 3-cycle memory, two reads in flight, redirect to 0x100. Required: both old responses discarded; the first output after the redirect has pc 0x100.
- **Redirect+rvalid same cycle:** Required: the arriving data is not enqueued, and drop_cnt = outstanding − 1.
- **Backpressure:** stall=1 until full. Required: count=QUEUE_DEPTH, mem_ren=0, head unchanged. Then release stall for one cycle: exactly one entry consumed and fetching resumes.
- **Async reset mid-flight:** assert rst between clock edges. Required: outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end: aligned line reads, unpacked into a PC-tagged
// show-ahead queue, with redirect flushing and stale-response discard.
module fetch_queue_stage #(
  parameter int          INSTRS_PER_LINE = 2,
  parameter int          QUEUE_DEPTH     = 8,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [63:0] RESET_PC        = 64'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         mem_ren,
  output logic [63:0]                  mem_raddr,
  input  logic                         mem_rvalid,
  input  logic [32*INSTRS_PER_LINE-1:0] mem_rdata,
  input  logic                         set_pc_valid,
  input  logic [63:0]                  set_pc,
  output logic                         output_valid,
  output logic [31:0]                  raw_instr,
  output logic [63:0]                  instr_pc,
  input  logic                         stall
);

  localparam int          LINE_BYTES = 4 * INSTRS_PER_LINE;
  localparam int          SLOT_W     = (INSTRS_PER_LINE > 1) ? $clog2(INSTRS_PER_LINE) : 1;
  localparam int          QPTR_W     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int          CNT_W      = $clog2(QUEUE_DEPTH + 1);
  localparam int          OS_W       = $clog2(MAX_OUTSTANDING + 1);
  localparam int          OPTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] IPL_U      = 32'(INSTRS_PER_LINE);
  localparam logic [31:0] QD_U       = 32'(QUEUE_DEPTH);
  localparam logic [31:0] MO_U       = 32'(MAX_OUTSTANDING);
  localparam logic [63:0] LINE_MASK  = ~(64'(LINE_BYTES) - 64'd1);

  logic [63:0]       fetchPc_q, fetchPc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [QPTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OS_W-1:0]   outstanding_q, outstanding_d;
  logic [OS_W-1:0]   dropCnt_q, dropCnt_d;
  logic [OPTR_W-1:0] offRd_q, offRd_d, offWr_q, offWr_d;

  logic [31:0]       instrMem_q [QUEUE_DEPTH];
  logic [63:0]       pcMem_q    [QUEUE_DEPTH];
  logic [SLOT_W-1:0] offSlot_q  [MAX_OUTSTANDING];
  logic [63:0]       offBase_q  [MAX_OUTSTANDING];

  logic [63:0]       lineBase;
  logic [SLOT_W-1:0] startSlot;
  logic [31:0]       liveLines;
  logic [31:0]       projected;
  logic              spaceOk;
  logic [SLOT_W-1:0] respSlot;
  logic [63:0]       respBase;
  logic              respLive;
  logic [31:0]       enqNum;
  logic              deq;

  function automatic logic [QPTR_W-1:0] qWrap(input logic [31:0] v);
    return QPTR_W'(v % QD_U);
  endfunction

  function automatic logic [OPTR_W-1:0] oWrap(input logic [31:0] v);
    return OPTR_W'(v % MO_U);
  endfunction

  assign lineBase  = fetchPc_q & LINE_MASK;
  assign startSlot = SLOT_W'((fetchPc_q & ~LINE_MASK) >> 2);

  // Reserve queue room for every live in-flight line before issuing another.
  assign liveLines = 32'(outstanding_q) - 32'(dropCnt_q);
  assign projected = 32'(count_q) + liveLines * IPL_U + IPL_U;
  assign spaceOk   = (projected <= QD_U);

  assign mem_ren   = !rst && !set_pc_valid && (32'(outstanding_q) < MO_U) && spaceOk;
  assign mem_raddr = mem_ren ? lineBase : 64'd0;

  assign respSlot = offSlot_q[offRd_q];
  assign respBase = offBase_q[offRd_q];
  assign respLive = mem_rvalid && !set_pc_valid && (dropCnt_q == '0);
  assign enqNum   = respLive ? (IPL_U - 32'(respSlot)) : 32'd0;

  assign output_valid = (count_q != '0);
  assign deq          = output_valid && !stall && !set_pc_valid;
  assign raw_instr    = output_valid ? instrMem_q[head_q] : 32'd0;
  assign instr_pc     = output_valid ? pcMem_q[head_q] : 64'd0;

  always_comb begin
    fetchPc_d     = fetchPc_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    dropCnt_d     = dropCnt_q;
    offRd_d       = offRd_q;
    offWr_d       = offWr_q;
    outstanding_d = outstanding_q + OS_W'(mem_ren) - OS_W'(mem_rvalid);

    if (mem_ren) begin
      fetchPc_d = lineBase + 64'(LINE_BYTES);
      offWr_d   = oWrap(32'(offWr_q) + 32'd1);
    end
    if (mem_rvalid) begin
      offRd_d = oWrap(32'(offRd_q) + 32'd1);
    end

    // Stale offset entries stay queued; drop_cnt makes their responses vanish.
    if (set_pc_valid) begin
      fetchPc_d = set_pc;
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      dropCnt_d = outstanding_q - OS_W'(mem_rvalid);
    end else begin
      if (mem_rvalid && (dropCnt_q != '0)) begin
        dropCnt_d = dropCnt_q - OS_W'(1);
      end
      count_d = CNT_W'(32'(count_q) + enqNum - 32'(deq));
      head_d  = qWrap(32'(head_q) + 32'(deq));
      tail_d  = qWrap(32'(tail_q) + enqNum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc_q     <= RESET_PC;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      outstanding_q <= '0;
      dropCnt_q     <= '0;
      offRd_q       <= '0;
      offWr_q       <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      outstanding_q <= outstanding_d;
      dropCnt_q     <= dropCnt_d;
      offRd_q       <= offRd_d;
      offWr_q       <= offWr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_ren) begin
      offSlot_q[offWr_q] <= startSlot;
      offBase_q[offWr_q] <= lineBase;
    end
  end

  // Slots below the start slot belong to a line entered mid-way and are skipped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < INSTRS_PER_LINE; i++) begin
      if (respLive && (i >= int'(respSlot))) begin
        instrMem_q[qWrap(32'(tail_q) + 32'(i) - 32'(respSlot))] <= mem_rdata[32*i +: 32];
        pcMem_q[qWrap(32'(tail_q) + 32'(i) - 32'(respSlot))]    <= respBase + 64'(4 * i);
      end
    end
  end

  rvalidLegal: assert property (@(posedge clk) disable iff (rst)
    !(mem_rvalid && (outstanding_q == '0)));

  noOverflow: assert property (@(posedge clk) disable iff (rst)
    (32'(count_q) + enqNum) <= (QD_U + 32'(deq)));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: in-order latency memory model plus
// a program-order PC stream reference that restarts at every redirect target.
module tb_fetch_queue_stage;

  localparam int          IPL   = 4;
  localparam int          QD    = 8;
  localparam int          MO    = 2;
  localparam logic [63:0] RPC   = 64'h0;
  localparam logic [63:0] LMASK = ~64'(4 * IPL - 1);

  logic              clk;
  logic              rst;
  logic              mem_ren;
  logic [63:0]       mem_raddr;
  logic              mem_rvalid;
  logic [32*IPL-1:0] mem_rdata;
  logic              set_pc_valid;
  logic [63:0]       set_pc;
  logic              output_valid;
  logic [31:0]       raw_instr;
  logic [63:0]       instr_pc;
  logic              stall;

  int          total;
  int          bad;
  int          cyc;
  logic [63:0] reqAddr [$];
  int          reqDue  [$];
  int          deliveredLines;
  bit          randLat;
  int          fixedLat;
  logic [63:0] expPc;
  logic [63:0] expLine;
  int          consumed;
  logic [63:0] firstPc;
  logic        sampOv;
  logic        sampRen;
  logic [63:0] sampPc;

  fetch_queue_stage #(
    .INSTRS_PER_LINE(IPL),
    .QUEUE_DEPTH(QD),
    .MAX_OUTSTANDING(MO),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_ren(mem_ren),
    .mem_raddr(mem_raddr),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .set_pc_valid(set_pc_valid),
    .set_pc(set_pc),
    .output_valid(output_valid),
    .raw_instr(raw_instr),
    .instr_pc(instr_pc),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic redir, input logic [63:0] target);
    stall        = st;
    set_pc_valid = redir;
    set_pc       = redir ? target : 64'd0;
  endtask

  function automatic logic [32*IPL-1:0] lineData(input logic [63:0] base);
    logic [32*IPL-1:0] d;
    logic [31:0]       a;
    a = base[31:0];
    for (int i = 0; i < IPL; i++) d[32*i +: 32] = a + 32'(4 * i);
    return d;
  endfunction

  // One clock: sample mid-cycle, update the reference, then drive memory data.
  task automatic tick();
    int due;
    #1;
    sampOv  = output_valid;
    sampRen = mem_ren;
    sampPc  = instr_pc;
    if (mem_rvalid) begin
      void'(reqAddr.pop_front());
      void'(reqDue.pop_front());
      deliveredLines++;
    end
    if (mem_ren) begin
      checkOutput("raddr", mem_raddr, expLine);
      expLine = expLine + 64'(4 * IPL);
      due = cyc + (randLat ? int'($urandom_range(1, 4)) : fixedLat);
      if (reqDue.size() > 0 && due <= reqDue[$]) due = reqDue[$] + 1;
      reqAddr.push_back(mem_raddr);
      reqDue.push_back(due);
    end else begin
      checkOutput("raddrIdle", mem_raddr, 64'd0);
    end
    if (output_valid && !stall && !set_pc_valid) begin
      checkOutput("pc", instr_pc, expPc);
      checkOutput("instr", {32'd0, raw_instr}, {32'd0, expPc[31:0]});
      if (consumed == 0) firstPc = instr_pc;
      consumed++;
      expPc = expPc + 64'd4;
    end
    if (set_pc_valid) begin
      expPc   = set_pc;
      expLine = set_pc & LMASK;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (reqDue.size() > 0 && reqDue[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = lineData(reqAddr[0]);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  endtask

  task automatic doReset();
    rst        = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    applyStimulus(1'b0, 1'b0, 64'd0);
    reqAddr.delete();
    reqDue.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rstValid", {63'd0, output_valid}, 64'd0);
    checkOutput("rstRen", {63'd0, mem_ren}, 64'd0);
    checkOutput("rstRaddr", mem_raddr, 64'd0);
    checkOutput("rstInstr", {32'd0, raw_instr}, 64'd0);
    checkOutput("rstPc", instr_pc, 64'd0);
    rst            = 1'b0;
    cyc            = 0;
    deliveredLines = 0;
    consumed       = 0;
    expPc          = RPC;
    expLine        = RPC & LMASK;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bit started;
    bit gap;
    bit found;
    total    = 0;
    bad      = 0;
    randLat  = 1'b0;
    fixedLat = 1;
    firstPc  = '0;

    // Reset and straight-line streaming with a 1-cycle memory.
    doReset();
    tick();
    checkOutput("renFirstCycle", {63'd0, sampRen}, 64'd1);
    started = 1'b0;
    gap     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (started && !sampOv) gap = 1'b1;
      if (sampOv) started = 1'b1;
    end
    checkOutput("noGaps", {63'd0, gap}, 64'd0);
    checkOutput("streamCount", {63'd0, (consumed >= 35)}, 64'd1);

    // Redirect into the middle of a line.
    applyStimulus(1'b0, 1'b1, 64'h14);
    tick();
    applyStimulus(1'b0, 1'b0, 64'd0);
    consumed = 0;
    tick();
    checkOutput("ovRedirE1", {63'd0, sampOv}, 64'd0);
    checkOutput("renRedirE1", {63'd0, sampRen}, 64'd1);
    tick();
    checkOutput("ovRedirE2", {63'd0, sampOv}, 64'd0);
    runCycles(20);
    checkOutput("partialFirst", firstPc, 64'h14);

    // Redirect in the same cycle a response arrives.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_rvalid) found = 1'b1;
      else tick();
    end
    checkOutput("rvalidFound", {63'd0, found}, 64'd1);
    applyStimulus(1'b0, 1'b1, 64'h200);
    tick();
    applyStimulus(1'b0, 1'b0, 64'd0);
    consumed = 0;
    tick();
    checkOutput("renAfterSame", {63'd0, sampRen}, 64'd1);
    runCycles(20);
    checkOutput("sameCycFirst", firstPc, 64'h200);

    // Two stale reads in flight on a 3-cycle memory.
    fixedLat = 3;
    doReset();
    runCycles(2);
    checkOutput("inflight", 64'(reqAddr.size()), 64'd2);
    applyStimulus(1'b0, 1'b1, 64'h100);
    tick();
    applyStimulus(1'b0, 1'b0, 64'd0);
    consumed = 0;
    runCycles(30);
    checkOutput("staleFirst", firstPc, 64'h100);

    // Backpressure until the queue fills, then a single-cycle release.
    fixedLat = 1;
    doReset();
    applyStimulus(1'b1, 1'b0, 64'd0);
    runCycles(10);
    checkOutput("headHeldMid", sampPc, 64'd0);
    runCycles(10);
    checkOutput("fullCount", 64'(deliveredLines * IPL), 64'(QD));
    checkOutput("renFull", {63'd0, sampRen}, 64'd0);
    checkOutput("ovFull", {63'd0, sampOv}, 64'd1);
    checkOutput("headHeld", sampPc, 64'd0);
    applyStimulus(1'b0, 1'b0, 64'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 64'd0);
    tick();
    checkOutput("oneConsumed", sampPc, 64'd4);
    checkOutput("oneConsumedCnt", 64'(consumed), 64'd1);
    applyStimulus(1'b0, 1'b0, 64'd0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (sampRen) found = 1'b1;
    end
    checkOutput("fetchResumes", {63'd0, found}, 64'd1);
    runCycles(20);

    // Asynchronous reset between clock edges while streaming.
    checkOutput("ovBeforeRst", {63'd0, output_valid}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncValid", {63'd0, output_valid}, 64'd0);
    checkOutput("asyncRen", {63'd0, mem_ren}, 64'd0);
    checkOutput("asyncRaddr", mem_raddr, 64'd0);
    checkOutput("asyncInstr", {32'd0, raw_instr}, 64'd0);
    checkOutput("asyncPc", instr_pc, 64'd0);
    mem_rvalid = 1'b0;

    // Randomized stall, redirect and memory latency.
    doReset();
    randLat = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic [63:0] tgt;
      tgt = 64'({$urandom_range(0, 65535), 2'b00});
      if ($urandom_range(0, 3) == 0) tgt = tgt | 64'hFFFF_0000_0000_0000;
      applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, tgt);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 64'd0);
    runCycles(10);
    checkOutput("randProgress", {63'd0, (consumed >= 100)}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
